parallel_join_tracker: RTL and testbench

PARALLEL_JOIN_TRACKER -- requirements
Module: parallel_join_tracker

---
 rtl/pjt_pkg.sv | 23 ++
 rtl/branch_timer.sv | 38 +++
 rtl/parallel_join_tracker.sv | 137 +++++++++++++
 tb/tb_parallel_join_tracker.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pjt_pkg.sv
// Shared types and helpers for the parallel fork/join tracker.
// Join policy codes, FSM state encoding and a small population-count helper.
package pjt_pkg;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2
    } join_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int MAX_BR = 4;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/branch_timer.sv
// Per-branch countdown: loaded with its duration at launch, active while non-zero,
// done pulse in the final active cycle. clear kills the count immediately.
module branch_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] dur,
    output logic             active,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    // countdown register, saturating at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= ZERO;
        end else if (clear) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= dur;
        end else if (cnt_r != ZERO) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign active = (cnt_r != ZERO);
    assign done   = (cnt_r == ONE);

endmodule

// File: rtl/parallel_join_tracker.sv
// Fork/join tracker: launches NUM_BR timed branches together and signals when the
// selected join policy is satisfied, then drains until every branch has finished.
module parallel_join_tracker
    import pjt_pkg::*;
#(
    parameter int NUM_BR = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [1:0]                join_mode,
    input  logic [NUM_BR*CNT_W-1:0]   dur,
    input  logic                      abort,
    output logic [NUM_BR-1:0]         br_active,
    output logic [NUM_BR-1:0]         br_done,
    output logic                      join_done,
    output logic [$clog2(NUM_BR+1)-1:0] completed_cnt,
    output logic                      busy
);

    localparam int CW = $clog2(NUM_BR + 1);

    state_e            state_r, state_s;
    logic [1:0]        mode_r;
    logic              first_r;
    logic              all_zero_r;
    logic [CW-1:0]     comp_r;
    logic              launch_s;
    logic              join_s;
    logic [NUM_BR-1:0] zero_s;
    logic [NUM_BR-1:0] left_s;
    logic [3:0]        done_pad_s;
    logic [3:0]        zero_pad_s;

    assign launch_s   = start_valid && (state_r == IDLE) && !abort;
    assign done_pad_s = 4'(br_done);
    assign zero_pad_s = 4'(zero_s);
    assign left_s     = br_active & ~br_done;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BR; gi++) begin : g_br
            assign zero_s[gi] = (dur[gi*CNT_W +: CNT_W] == {CNT_W{1'b0}});

            branch_timer #(.CNT_W(CNT_W)) u_timer (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (launch_s),
                .clear  (abort),
                .dur    (dur[gi*CNT_W +: CNT_W]),
                .active (br_active[gi]),
                .done   (br_done[gi])
            );
        end
    endgenerate

    // join condition; the reserved mode code falls into the JOIN_ALL default
    always_comb begin
        join_s = 1'b0;
        if (state_r == RUN) begin
            if (first_r && ((mode_r == JOIN_NONE) || all_zero_r)) begin
                join_s = 1'b1;
            end else begin
                case (mode_r)
                    JOIN_NONE: join_s = 1'b0;
                    JOIN_ANY:  join_s = |br_done;
                    default:   join_s = (|br_done) && (br_done == br_active);
                endcase
            end
        end else begin
            join_s = 1'b0;
        end
    end

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (abort)               state_s = IDLE;
                else if (!join_s)        state_s = RUN;
                else if (left_s != '0)   state_s = DRAIN;
                else                     state_s = IDLE;
            end
            DRAIN: begin
                if (abort || (left_s == '0)) state_s = IDLE;
                else                         state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // state register and per-launch context
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            mode_r     <= 2'b00;
            first_r    <= 1'b0;
            all_zero_r <= 1'b0;
        end else begin
            state_r <= state_s;
            first_r <= launch_s;
            if (launch_s) begin
                mode_r     <= join_mode;
                all_zero_r <= &zero_s;
            end else begin
                mode_r     <= mode_r;
                all_zero_r <= all_zero_r;
            end
        end
    end

    // zero-duration branches count as complete straight from launch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            comp_r <= {CW{1'b0}};
        end else if (launch_s) begin
            comp_r <= CW'(popcount4(zero_pad_s));
        end else if (abort) begin
            comp_r <= comp_r;
        end else begin
            comp_r <= comp_r + CW'(popcount4(done_pad_s));
        end
    end

    assign start_ready   = (state_r == IDLE);
    assign busy          = (state_r != IDLE);
    assign join_done     = join_s;
    assign completed_cnt = comp_r;

endmodule

// File: tb/tb_parallel_join_tracker.sv
// Self-checking bench for parallel_join_tracker: directed scenarios plus random
// launches, each checked cycle by cycle against a timeline model of the branches.
module tb_parallel_join_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  join_mode;
    logic [15:0] dur;
    logic        abort;
    logic [1:0]  br_active;
    logic [1:0]  br_done;
    logic        join_done;
    logic [1:0]  completed_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    parallel_join_tracker #(.NUM_BR(2), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .join_mode     (join_mode),
        .dur           (dur),
        .abort         (abort),
        .br_active     (br_active),
        .br_done       (br_done),
        .join_done     (join_done),
        .completed_cnt (completed_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [1:0] exp_cnt);
        chk({tag, "_active"}, 32'(br_active), 32'd0);
        chk({tag, "_done"},   32'(br_done), 32'd0);
        chk({tag, "_join"},   32'(join_done), 32'd0);
        chk({tag, "_cnt"},    32'(completed_cnt), 32'(exp_cnt));
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_ready"},  32'(start_ready), 32'd1);
    endtask

    // One launch of durations {d1,d0}; ab/rs > 0 assert abort/reset during cycle T+ab / T+rs.
    task automatic run_case(input string tag, input logic [1:0] m,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input int ab, input int rs);
        int d [2];
        int mx, mn, jc, last, n, held;
        bit allz;
        logic [1:0] e_act, e_done, e_cnt;
        logic e_join, e_busy;
        d[0] = int'(d0);
        d[1] = int'(d1);
        mx = (d[0] > d[1]) ? d[0] : d[1];
        mn = 1000;
        foreach (d[i]) if (d[i] > 0 && d[i] < mn) mn = d[i];
        allz = (mx == 0);
        if (m == 2'd2 || allz) jc = 1;
        else if (m == 2'd1)    jc = mn;
        else                   jc = mx;
        last = (jc > mx) ? jc : mx;
        n = last + 2;
        if (ab > 0) n = ab + 3;
        if (rs > 0) n = rs + 3;
        held = 0;
        if (ab > 0) foreach (d[i]) if (d[i] < ab) held++;

        @(negedge clk);
        chk({tag, "_ready_pre"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        join_mode   = m;
        dur         = {d1, d0};
        @(posedge clk);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start_valid = 1'b0;
            abort       = 1'b0;
            rst_n       = 1'b1;
            if ((ab > 0 && k > ab) || (rs > 0 && k > rs)) begin
                e_act  = 2'b00;
                e_done = 2'b00;
                e_join = 1'b0;
                e_busy = 1'b0;
                e_cnt  = (ab > 0) ? 2'(held) : 2'd0;
            end else begin
                e_act  = {d[1] >= k, d[0] >= k};
                e_done = {d[1] == k, d[0] == k};
                e_join = (k == jc);
                e_busy = (k <= last);
                e_cnt  = 2'(int'(d[0] < k) + int'(d[1] < k));
            end
            chk({tag, "_active"}, 32'(br_active), 32'(e_act));
            chk({tag, "_done"},   32'(br_done), 32'(e_done));
            chk({tag, "_join"},   32'(join_done), 32'(e_join));
            chk({tag, "_cnt"},    32'(completed_cnt), 32'(e_cnt));
            chk({tag, "_busy"},   32'(busy), 32'(e_busy));
            chk({tag, "_ready"},  32'(start_ready), 32'(!e_busy));
            if (k == ab) abort = 1'b1;
            if (k == rs) rst_n = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        join_mode   = 2'd0;
        dur         = 16'd0;
        abort       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset", 2'd0);
        rst_n = 1'b1;

        run_case("none_20_10", 2'd2, 8'd10, 8'd20, 0, 0);
        run_case("any_20_10",  2'd1, 8'd10, 8'd20, 0, 0);
        run_case("all_10_10",  2'd0, 8'd10, 8'd10, 0, 0);
        run_case("all_0_0",    2'd0, 8'd0,  8'd0,  0, 0);

        // abort together with start_valid in IDLE must not launch
        @(negedge clk);
        start_valid = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        abort       = 1'b0;
        chk_idle_outputs("abort_idle", 2'd2);

        run_case("all_abort",  2'd0, 8'd10, 8'd20, 5, 0);
        run_case("all_reset",  2'd0, 8'd10, 8'd20, 0, 15);
        run_case("all_after_reset", 2'd0, 8'd10, 8'd10, 0, 0);
        run_case("rsvd_mode",  2'd3, 8'd7,  8'd3,  0, 0);
        run_case("any_zero",   2'd1, 8'd0,  8'd6,  0, 0);
        run_case("all_one",    2'd0, 8'd1,  8'd0,  0, 0);

        for (int r = 0; r < 10; r++) begin
            run_case("rand", 2'($urandom_range(0, 3)),
                     8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
